rr_gnt_arbiter: RTL and testbench

//   Round-robin arbiter that produces the registered one-hot grant vector consumed by
//   the grant interface (_if.gnt) and its clocking-block samplers. It replaces the

---
 rtl/rr_gnt_arbiter.sv | 102 ++++++++++
 tb/tb_rr_gnt_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_gnt_arbiter.sv
// Round-robin arbiter with registered one-hot grant, bounded hold under contention
// and zero-bubble hand-off between owners.
//
// state | meaning
// IDLE  | no owner, gnt all-zero, waiting for any request
// GRANT | gnt_id owns the grant; hold_cnt counts its consecutive cycles
module rr_gnt_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IW      = $clog2(N),
    localparam int HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hold_cnt;

    logic [N-1:0]  others;
    logic          pending;
    logic [IW-1:0] nxt;
    logic [IW-1:0] idle_pick;
    logic [IW-1:0] hand_pick;
    logic          at_limit;

    // First set bit of r at or after index s, wrapping from N-1 back to 0.
    function automatic logic [IW-1:0] search(input logic [N-1:0] r, input logic [IW-1:0] s);
        int idx;
        search = s;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(s) + k) % N;
            if (r[idx]) search = IW'(idx);
        end
    endfunction

    // The current owner is excluded so a preempt can never re-grant it.
    assign others    = req & ~gnt;
    assign pending   = |others;
    assign nxt       = (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
    assign idle_pick = search(req, ptr);
    assign hand_pick = search(others, nxt);
    assign at_limit  = (hold_cnt == HW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_vld  <= 1'b0;
            gnt_id   <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        gnt      <= {{(N-1){1'b0}}, 1'b1} << idle_pick;
                        gnt_vld  <= 1'b1;
                        gnt_id   <= idle_pick;
                        hold_cnt <= HW'(1);
                    end
                end
                GRANT: begin
                    if (!req[gnt_id]) begin
                        ptr <= nxt;
                        if (pending) begin
                            gnt      <= {{(N-1){1'b0}}, 1'b1} << hand_pick;
                            gnt_id   <= hand_pick;
                            hold_cnt <= HW'(1);
                        end else begin
                            state    <= IDLE;
                            gnt      <= '0;
                            gnt_vld  <= 1'b0;
                            gnt_id   <= '0;
                            hold_cnt <= '0;
                        end
                    end else if (at_limit && pending) begin
                        ptr      <= nxt;
                        gnt      <= {{(N-1){1'b0}}, 1'b1} << hand_pick;
                        gnt_id   <= hand_pick;
                        hold_cnt <= HW'(1);
                    end else if (!at_limit) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_gnt_arbiter.sv
// Bench for rr_gnt_arbiter: three instances (MAX_HOLD 1, 3, 8) share one stimulus;
// a scoreboard queue carries the reference model's expectations to a negedge monitor.
module tb_rr_gnt_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt_w [3];
    logic       vld_w [3];
    logic [1:0] id_w  [3];

    int checks = 0;
    int errors = 0;

    rr_gnt_arbiter #(.N(4), .MAX_HOLD(1)) u_mh1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_w[0]), .gnt_vld(vld_w[0]), .gnt_id(id_w[0]));
    rr_gnt_arbiter #(.N(4), .MAX_HOLD(3)) u_mh3 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_w[1]), .gnt_vld(vld_w[1]), .gnt_id(id_w[1]));
    rr_gnt_arbiter #(.N(4), .MAX_HOLD(8)) u_mh8 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_w[2]), .gnt_vld(vld_w[2]), .gnt_id(id_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0][3:0] g;
        logic [2:0]      v;
        logic [2:0][1:0] id;
        logic [2:0]      chk_id;
    } exp_t;

    exp_t sbq[$];

    // Reference model: owner index (-1 = none), cycles held, round-robin start point.
    int own  [3] = '{-1, -1, -1};
    int held [3] = '{0, 0, 0};
    int rptr [3] = '{0, 0, 0};
    int mh   [3] = '{1, 3, 8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int s);
        for (int k = 0; k < 4; k++)
            if (r[(s + k) % 4]) return (s + k) % 4;
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] q);
        exp_t e;
        logic [3:0] oth;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                own[i] = -1; held[i] = 0; rptr[i] = 0;
            end else if (own[i] < 0) begin
                if (q != 0) begin
                    own[i] = first_from(q, rptr[i]); held[i] = 1;
                end
            end else begin
                oth = q & ~(4'b0001 << own[i]);
                if (!q[own[i]]) begin
                    rptr[i] = (own[i] + 1) % 4;
                    own[i]  = (oth != 0) ? first_from(oth, rptr[i]) : -1;
                    held[i] = (own[i] < 0) ? 0 : 1;
                end else if (held[i] >= mh[i] && oth != 0) begin
                    rptr[i] = (own[i] + 1) % 4;
                    own[i]  = first_from(oth, rptr[i]);
                    held[i] = 1;
                end else if (held[i] < mh[i]) begin
                    held[i]++;
                end
            end
            e.g[i]      = (own[i] < 0) ? 4'b0000 : (4'b0001 << own[i]);
            e.v[i]      = (own[i] >= 0);
            e.id[i]     = (own[i] < 0) ? 2'd0 : 2'(own[i]);
            e.chk_id[i] = (own[i] >= 0) || r;
        end
        sbq.push_back(e);
    endtask

    // Present inputs, let the DUTs sample them at the next edge, return #1 after it.
    task automatic step(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        model_edge(r, q);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("gnt[%0d]", i), 32'(gnt_w[i]), 32'(e.g[i]));
                    chk($sformatf("gnt_vld[%0d]", i), 32'(vld_w[i]), 32'(e.v[i]));
                    if (e.chk_id[i])
                        chk($sformatf("gnt_id[%0d]", i), 32'(id_w[i]), 32'(e.id[i]));
                    chk($sformatf("onehot0[%0d]", i), 32'($onehot0(gnt_w[i])), 32'd1);
                    chk($sformatf("vld_or[%0d]", i), 32'(vld_w[i]), 32'(|gnt_w[i]));
                    if (vld_w[i])
                        chk($sformatf("gnt_at_id[%0d]", i), 32'(gnt_w[i][id_w[i]]), 32'd1);
                end
            end
        end
    end

    initial begin : stim
        logic [3:0] q;
        logic       r;
        logic [3:0] e;
        rst = 1'b1;
        req = 4'hF;

        // reset held for two edges with all requests up
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 4'hF);
            for (int i = 0; i < 3; i++) begin
                chk("rst_gnt", 32'(gnt_w[i]), 32'h0);
                chk("rst_vld", 32'(vld_w[i]), 32'h0);
                chk("rst_id", 32'(id_w[i]), 32'h0);
            end
        end
        step(1'b0, 4'hF);
        for (int i = 0; i < 3; i++) chk("post_rst_gnt", 32'(gnt_w[i]), 32'h1);

        // single requester
        step(1'b0, 4'h0);
        step(1'b0, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            chk("single_gnt", 32'(gnt_w[i]), 32'h4);
            chk("single_id", 32'(id_w[i]), 32'd2);
        end
        step(1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            chk("single_rel_gnt", 32'(gnt_w[i]), 32'h0);
            chk("single_rel_vld", 32'(vld_w[i]), 32'h0);
        end

        // per-cycle rotation with MAX_HOLD=1
        step(1'b1, 4'h0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'hF);
            e = 4'b0001 << (k % 4);
            chk("rotate_mh1", 32'(gnt_w[0]), 32'(e));
        end

        // bounded hold of 3 cycles between two requesters
        step(1'b1, 4'h0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'b0011);
            e = ((k / 3) % 2 == 0) ? 4'b0001 : 4'b0010;
            chk("hold_mh3", 32'(gnt_w[1]), 32'(e));
        end

        // wrap hand-off from owner 3 to owner 0 with no idle cycle
        step(1'b1, 4'h0);
        step(1'b0, 4'b1000);
        step(1'b0, 4'b1001);
        step(1'b0, 4'b1001);
        chk("wrap_hold", 32'(gnt_w[2]), 32'h8);
        step(1'b0, 4'b0001);
        chk("wrap_gnt", 32'(gnt_w[2]), 32'h1);
        chk("wrap_id", 32'(id_w[2]), 32'd0);
        chk("wrap_vld", 32'(vld_w[2]), 32'd1);

        // reset pulse mid-grant restores the pointer
        step(1'b1, 4'h0);
        step(1'b0, 4'b0010);
        step(1'b0, 4'hF);
        chk("midrst_pre", 32'(gnt_w[2]), 32'h2);
        step(1'b1, 4'hF);
        for (int i = 0; i < 3; i++) chk("midrst_gnt", 32'(gnt_w[i]), 32'h0);
        step(1'b0, 4'hF);
        for (int i = 0; i < 3; i++) chk("midrst_after", 32'(gnt_w[i]), 32'h1);

        // randomized traffic; requests tend to persist so holds and preempts occur
        q = 4'h0;
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) q[$urandom_range(0, 3)] ^= 1'b1;
            step(r, q);
        end

        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
